jpeg_input_cx_subsample: RTL and testbench

JPEG_INPUT_CX_SUBSAMPLE -- requirements
Module: jpeg_input_cx_subsample

---
 rtl/jpeg_cx_pkg.sv | 18 +
 rtl/jpeg_cx_acc_bank.sv | 40 ++++
 rtl/jpeg_input_cx_subsample.sv | 111 +++++++++++
 tb/tb_jpeg_input_cx_subsample.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_cx_pkg.sv
// Shared sizes and helpers for the chroma subsampler: cell mapping and output rounding.
package jpeg_cx_pkg;

    localparam int JPEG_CX_CELLS          = 64;
    localparam int JPEG_CX_MCU420_SAMPLES = 256;
    localparam int JPEG_CX_BLK444_SAMPLES = 64;
    localparam int JPEG_CX_ACC_W          = 10;

    // 4:2:0 folds each 2x2 neighbourhood of the 16x16 MCU onto one 8x8 cell.
    function automatic logic [5:0] cell_addr(input logic m420, input logic [7:0] idx);
        return m420 ? {idx[7:5], idx[3:1]} : idx[5:0];
    endfunction

    function automatic logic [7:0] cell_out(input logic m420, input logic [JPEG_CX_ACC_W-1:0] acc);
        return m420 ? 8'(({1'b0, acc} + 11'd2) >> 2) : acc[7:0];
    endfunction

endpackage

// File: rtl/jpeg_cx_acc_bank.sv
// One 64-cell accumulator bank with per-cell touched bits and an async-free clear.
module jpeg_cx_acc_bank
    import jpeg_cx_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic                     accum_i,
    input  logic [5:0]               wr_addr_i,
    input  logic [7:0]               wr_data_i,
    input  logic [5:0]               rd_addr_i,
    output logic [JPEG_CX_ACC_W-1:0] rd_data_o
);

    logic [JPEG_CX_ACC_W-1:0] cells [JPEG_CX_CELLS];
    logic [JPEG_CX_CELLS-1:0] touched;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            touched <= '0;
        end else if (wr_en_i) begin
            touched[wr_addr_i] <= 1'b1;
        end
    end

    // Cell contents need no reset: an untouched cell is overwritten by its first sample.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !rst_i && !clear_i) begin
            if (accum_i && touched[wr_addr_i]) begin
                cells[wr_addr_i] <= cells[wr_addr_i] + JPEG_CX_ACC_W'(wr_data_i);
            end else begin
                cells[wr_addr_i] <= JPEG_CX_ACC_W'(wr_data_i);
            end
        end
    end

    assign rd_data_o = touched[rd_addr_i] ? cells[rd_addr_i] : '0;

endmodule

// File: rtl/jpeg_input_cx_subsample.sv
// Chroma input stage: ping-pong accumulation of 4:2:0 MCUs or 4:4:4 blocks, 8x8 raster drain.
module jpeg_input_cx_subsample
    import jpeg_cx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        mode420_i,
    input  logic        push_i,
    input  logic [7:0]  wr_idx_i,
    input  logic [7:0]  data_in_i,
    output logic        accept_o,
    input  logic        pop_i,
    output logic [7:0]  data_out_o,
    output logic        valid_o,
    output logic [31:0] level_o
);

    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               full;
    logic [1:0]               bank_m420;
    logic [8:0]               wr_cnt;
    logic [6:0]               ld_cnt;
    logic                     push_ok;
    logic                     pop_ok;
    logic                     cur_m420;
    logic                     last_push;
    logic                     last_pop;
    logic                     load_ok;
    logic [1:0]               wr_en;
    logic [1:0]               clr;
    logic [JPEG_CX_ACC_W-1:0] rd_data [2];

    assign accept_o = ~(full[0] & full[1]);
    assign push_ok  = push_i & accept_o & ~flush_i;
    assign pop_ok   = pop_i & valid_o & ~flush_i;

    // Mode is captured on a bank's first push; later pushes use the captured value.
    assign cur_m420  = (wr_cnt == '0) ? mode420_i : bank_m420[wr_ptr];
    assign last_push = push_ok && (wr_cnt == (cur_m420 ? 9'(JPEG_CX_MCU420_SAMPLES - 1)
                                                       : 9'(JPEG_CX_BLK444_SAMPLES - 1)));
    assign last_pop  = pop_ok && (ld_cnt == 7'(JPEG_CX_CELLS));
    assign load_ok   = (!valid_o || pop_ok) && full[rd_ptr]
                       && (ld_cnt < 7'(JPEG_CX_CELLS)) && !flush_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_en[b] = push_ok && (wr_ptr == 1'(b));
        assign clr[b]   = flush_i || (last_pop && (rd_ptr == 1'(b)));

        jpeg_cx_acc_bank u_bank (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clear_i   (clr[b]),
            .wr_en_i   (wr_en[b]),
            .accum_i   (cur_m420),
            .wr_addr_i (cell_addr(cur_m420, wr_idx_i)),
            .wr_data_i (data_in_i),
            .rd_addr_i (ld_cnt[5:0]),
            .rd_data_o (rd_data[b])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            full      <= '0;
            bank_m420 <= '0;
            wr_cnt    <= '0;
            ld_cnt    <= '0;
            level_o   <= '0;
            valid_o   <= 1'b0;
            if (rst_i) begin
                data_out_o <= '0;
            end
        end else begin
            if (push_ok) begin
                if (wr_cnt == '0) begin
                    bank_m420[wr_ptr] <= mode420_i;
                end
                if (last_push) begin
                    wr_cnt       <= '0;
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= ~wr_ptr;
                end else begin
                    wr_cnt <= wr_cnt + 9'd1;
                end
            end

            // ld_cnt counts cells presented from the read bank; it sits at 64 until the last pop.
            if (last_pop) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
                ld_cnt       <= '0;
            end else if (load_ok) begin
                ld_cnt <= ld_cnt + 7'd1;
            end

            if (load_ok) begin
                data_out_o <= cell_out(bank_m420[rd_ptr], rd_data[rd_ptr]);
                valid_o    <= 1'b1;
            end else if (pop_ok) begin
                valid_o <= 1'b0;
            end

            level_o <= level_o + (last_push ? 32'd64 : 32'd0) - {31'd0, pop_ok};
        end
    end

endmodule

// File: tb/tb_jpeg_input_cx_subsample.sv
// Self-checking bench: queue-based reference model, vector table and corner-case sequences.
module tb_jpeg_input_cx_subsample;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, mode420_i, push_i, pop_i;
    logic [7:0]  wr_idx_i, data_in_i, data_out_o;
    logic        accept_o, valid_o;
    logic [31:0] level_o;

    always #5 clk_i = ~clk_i;

    jpeg_input_cx_subsample dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .mode420_i  (mode420_i),
        .push_i     (push_i),
        .wr_idx_i   (wr_idx_i),
        .data_in_i  (data_in_i),
        .accept_o   (accept_o),
        .pop_i      (pop_i),
        .data_out_o (data_out_o),
        .valid_o    (valid_o),
        .level_o    (level_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: partial bank as plain sums, completed outputs as a queue.
    int  exp_q[$];
    int  m_sum[64];
    bit  m_touch[64];
    int  m_cnt = 0;
    bit  m_mode = 1'b0;
    int  n_pops = 0;
    int  last_pop_val = 0;
    bit  mon_en = 1'b0;

    task automatic model_clear_bank();
        for (int k = 0; k < 64; k++) begin
            m_sum[k]   = 0;
            m_touch[k] = 1'b0;
        end
        m_cnt = 0;
    endtask

    always @(negedge clk_i) begin
        bit acc_now;
        int c;
        int row;
        int col;
        acc_now = ((exp_q.size() + 63) / 64) < 2;
        if (mon_en) begin
            check("level", level_o, exp_q.size());
            check("accept", accept_o, acc_now);
            check("valid_without_data", valid_o && (exp_q.size() == 0), 0);
        end
        if (rst_i || flush_i) begin
            exp_q.delete();
            model_clear_bank();
        end else begin
            if (pop_i && valid_o && exp_q.size() > 0) begin
                check("pop_data", data_out_o, exp_q[0]);
                last_pop_val = data_out_o;
                void'(exp_q.pop_front());
                n_pops++;
            end
            if (push_i && acc_now) begin
                if (m_cnt == 0) m_mode = mode420_i;
                if (m_mode) begin
                    row = wr_idx_i / 16;
                    col = wr_idx_i % 16;
                    c   = (row / 2) * 8 + (col / 2);
                end else begin
                    c = wr_idx_i % 64;
                end
                if (m_mode && m_touch[c]) m_sum[c] = m_sum[c] + data_in_i;
                else m_sum[c] = data_in_i;
                m_touch[c] = 1'b1;
                m_cnt++;
                if (m_cnt == (m_mode ? 256 : 64)) begin
                    for (int k = 0; k < 64; k++)
                        exp_q.push_back(m_mode ? (m_sum[k] + 2) / 4 : m_sum[k] % 256);
                    model_clear_bank();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_push(input logic [7:0] idx, input logic [7:0] d);
        push_i   = 1'b1;
        wr_idx_i = idx;
        data_in_i = d;
        tick();
        push_i = 1'b0;
    endtask

    // kind: 0 const val, 1 data=index, 2 random; order: 0 ascending, 1 descending, 2 permuted
    task automatic fill_bank(input bit m, input int kind, input int val, input int order);
        int n;
        int stride;
        int off;
        n      = m ? 256 : 64;
        stride = $urandom_range(0, 63) * 2 + 1;
        off    = $urandom_range(0, 255);
        mode420_i = m;
        for (int k = 0; k < n; k++) begin
            int idx;
            int d;
            case (order)
                0:       idx = k;
                1:       idx = n - 1 - k;
                default: idx = (k * stride + off) % n;
            endcase
            d = (kind == 0) ? val : (kind == 1) ? idx : int'($urandom_range(0, 255));
            do_push(8'(idx), 8'(d));
        end
    endtask

    task automatic rand_bank(input bit m);
        int n;
        int stride;
        int off;
        n      = m ? 256 : 64;
        stride = $urandom_range(0, 63) * 2 + 1;
        off    = $urandom_range(0, 255);
        for (int k = 0; k < n; k++) begin
            int guard;
            guard = 0;
            while ((!accept_o || $urandom_range(0, 3) == 0) && guard < 2000) begin
                push_i = 1'b0;
                pop_i  = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            if (guard >= 2000) check("accept_timeout", accept_o, 1);
            mode420_i = (k == 0) ? m : 1'($urandom_range(0, 1));
            pop_i     = 1'($urandom_range(0, 1));
            do_push(8'((k * stride + off) % n), 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !valid_o; i++) tick();
        check("wait_valid", valid_o, 1);
    endtask

    task automatic drain();
        pop_i = 1'b1;
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        check("drain_done", exp_q.size(), 0);
        pop_i = 1'b0;
        check("drain_level", level_o, 0);
        check("drain_valid", valid_o, 0);
    endtask

    typedef struct {
        bit m420;
        int kind;
        int val;
        int order;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t vecs[6];
    int   base;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 0, 200, 2, 200, 200};
        vecs[1] = '{1'b1, 0, 255, 2, 255, 255};
        vecs[2] = '{1'b1, 0, 1,   2, 1,   1};
        vecs[3] = '{1'b0, 1, 0,   1, 0,   63};
        vecs[4] = '{1'b1, 1, 0,   2, 9,   247};
        vecs[5] = '{1'b0, 0, 0,   2, 0,   0};

        rst_i = 1'b1; flush_i = 1'b0; mode420_i = 1'b1; push_i = 1'b0; pop_i = 1'b0;
        wr_idx_i = '0; data_in_i = '0;
        repeat (3) tick();
        check("rst_valid", valid_o, 0);
        check("rst_data", data_out_o, 0);
        check("rst_accept", accept_o, 1);
        check("rst_level", level_o, 0);
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // all-200 MCU, pop held: valid exactly two edges after the last push
        pop_i = 1'b1;
        fill_bank(1'b1, 0, 200, 0);
        check("s30_valid_edge1", valid_o, 0);
        check("s30_level", level_o, 64);
        tick();
        check("s30_valid_edge2", valid_o, 1);
        check("s30_data", data_out_o, 200);
        drain();

        // rounding: cell 0 receives 1,2,2,2
        pop_i = 1'b0;
        mode420_i = 1'b1;
        for (int k = 0; k < 256; k++)
            do_push(8'(k), (k == 0) ? 8'd1 : (k == 1 || k == 16 || k == 17) ? 8'd2 : 8'd0);
        wait_valid();
        check("s31_first", data_out_o, 2);
        drain();
        check("s31_last", last_pop_val, 0);

        for (int v = 0; v < 6; v++) begin
            pop_i = 1'b0;
            fill_bank(vecs[v].m420, vecs[v].kind, vecs[v].val, vecs[v].order);
            wait_valid();
            check($sformatf("vec%0d_first", v), data_out_o, vecs[v].exp_first);
            drain();
            check($sformatf("vec%0d_last", v), last_pop_val, vecs[v].exp_last);
        end

        // both banks full, no consumer: pushes ignored, output held
        pop_i = 1'b0;
        fill_bank(1'b1, 0, 10, 2);
        fill_bank(1'b1, 0, 20, 2);
        tick();
        tick();
        check("s33_accept", accept_o, 0);
        check("s33_level", level_o, 128);
        check("s33_valid", valid_o, 1);
        check("s33_data", data_out_o, 10);
        for (int k = 0; k < 5; k++) begin
            do_push(8'(k), 8'd99);
            check("s33_hold", data_out_o, 10);
            check("s33_hold_valid", valid_o, 1);
        end
        check("s33_level_after", level_o, 128);
        drain();
        check("s33_last", last_pop_val, 20);

        // flush with push and pop in the middle of a drain
        fill_bank(1'b1, 2, 0, 2);
        wait_valid();
        base  = n_pops;
        pop_i = 1'b1;
        for (int i = 0; i < 200 && (n_pops - base) < 30; i++) tick();
        check("s34_reach30", (n_pops - base) >= 30, 1);
        flush_i = 1'b1; push_i = 1'b1; wr_idx_i = 8'd0; data_in_i = 8'd5;
        tick();
        flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        check("s34_valid", valid_o, 0);
        check("s34_level", level_o, 0);
        check("s34_accept", accept_o, 1);
        fill_bank(1'b1, 2, 0, 2);
        drain();

        // reset in the middle of a bank
        mode420_i = 1'b1;
        for (int k = 0; k < 100; k++) do_push(8'(k), 8'd7);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("s35_valid", valid_o, 0);
        check("s35_data", data_out_o, 0);
        check("s35_accept", accept_o, 1);
        check("s35_level", level_o, 0);
        fill_bank(1'b1, 2, 0, 2);
        drain();

        // random traffic, random consumer, mode toggling mid-bank
        for (int b = 0; b < 12; b++) rand_bank(1'($urandom_range(0, 1)));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
